// File: rtl/mul_issue_ctrl_if.sv
// Handshake bundle for mul_issue_ctrl: operand stream in, result stream out, multiplier drive.
// slave is the controller's view; master is the environment's view.
interface mul_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_busy;
    logic        mul_done;
    logic [15:0] mul_result;
    logic        err;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_busy, mul_done, mul_result,
        output in_ready, out_valid, out_result, mul_start, mul_a, mul_b, err
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_busy, mul_done, mul_result,
        input  in_ready, out_valid, out_result, mul_start, mul_a, mul_b, err
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller for an external 8x8 signed multiplier: buffers operand pairs in a FIFO,
// issues one operation at a time, captures the product and flags a sticky timeout.
module mul_issue_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input logic             clk,
    input logic             rst_n,
    mul_issue_ctrl_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

    state_e          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic [7:0]      mul_a_q, mul_b_q;
    logic [15:0]     out_result_q;
    logic            out_valid_q;
    logic            err_q;

    logic push, pop, full, empty;
    logic load_ops, capture, timeout;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full;

    assign bus.in_ready   = !full;
    assign bus.mul_start  = (state_q == StIssue);
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.err        = err_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        load_ops   = 1'b0;
        pop        = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A lingering done or unread result from an earlier op must not overlap a new issue.
                if (!empty && !bus.mul_busy && !bus.mul_done && !out_valid_q) begin
                    load_ops = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                pop        = 1'b1;
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (bus.mul_done) begin
                    state_d = StCapture;
                end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    wait_cnt_d = 8'(TIMEOUT);
                    state_d    = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StCapture: begin
                capture = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wait_cnt_q   <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
            if (load_ops) begin
                {mul_a_q, mul_b_q} <= mem_q[rd_ptr_q];
            end
            if (capture) begin
                out_valid_q  <= 1'b1;
                out_result_q <= bus.mul_result;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural multiplier driven on the falling edge.
module tb_mul_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 63;

    logic clk = 1'b0;
    logic rst_n;
    mul_issue_ctrl_if bus ();

    mul_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Multiplier model: never reset, result shows garbage during the done cycle.
    int          lat        = 3;
    bit          hang       = 1'b0;
    bit          force_busy = 1'b0;
    int          inject_req = 0;
    int          inject_ack = 0;
    int          m_cnt      = 0;
    logic        m_busy     = 1'b0;
    logic        m_done     = 1'b0;
    logic [15:0] m_prod     = '0;
    logic signed [7:0] m_a, m_b;

    always @(negedge clk) begin
        if (m_done) bus.mul_result = m_prod;
        m_done = 1'b0;
        if (bus.mul_start && !hang) begin
            m_a    = bus.mul_a;
            m_b    = bus.mul_b;
            m_prod = 16'(m_a * m_b);
            m_cnt  = lat;
            m_busy = 1'b1;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy         = 1'b0;
                m_done         = 1'b1;
                bus.mul_result = 16'hDEAD;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        if (inject_req != inject_ack) begin
            inject_ack = inject_ack + 1;
            m_done     = 1'b1;
        end
        bus.mul_done = m_done;
        bus.mul_busy = m_busy | force_busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        check_eq("push_accept", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.mul_start && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, bus.mul_start, 1);
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, bus.out_valid, 1);
    endtask

    initial begin
        logic [15:0] exp_q [5];
        int idx;
        int n;
        int seen_start;
        int seen_valid;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_result", bus.out_result, 16'h0000);
        check_eq("rst_mul_start", bus.mul_start, 0);
        check_eq("rst_mul_a", bus.mul_a, 8'h00);
        check_eq("rst_mul_b", bus.mul_b, 8'h00);
        check_eq("rst_err", bus.err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // -3 * 5
        push(8'hFD, 8'h05);
        wait_start("s1_start");
        check_eq("s1_mul_a", bus.mul_a, 8'hFD);
        check_eq("s1_mul_b", bus.mul_b, 8'h05);
        tick();
        check_eq("s1_start_pulse", bus.mul_start, 0);
        n = 0;
        while (!bus.mul_done && n < 50) begin
            tick();
            n++;
        end
        check_eq("s1_done_seen", bus.mul_done, 1);
        check_eq("s1_no_early_valid", bus.out_valid, 0);
        tick();
        check_eq("s1_valid", bus.out_valid, 1);
        check_eq("s1_result", bus.out_result, 16'hFFF1);
        bus.out_ready = 1'b1;
        tick();
        check_eq("s1_consumed", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Two back-to-back extremes, second issue held off by the unread result
        push(8'h7F, 8'h7F);
        push(8'h80, 8'h80);
        wait_out("s2_first_valid");
        check_eq("s2_first", bus.out_result, 16'h3F01);
        seen_start = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.mul_start) seen_start++;
        end
        check_eq("s2_no_issue_while_held", seen_start, 0);
        check_eq("s2_first_held", bus.out_result, 16'h3F01);
        bus.out_ready = 1'b1;
        wait_start("s2_second_start");
        check_eq("s2_second_mul_a", bus.mul_a, 8'h80);
        wait_out("s2_second_valid");
        check_eq("s2_second", bus.out_result, 16'h4000);
        tick();
        bus.out_ready = 1'b0;

        // Fill the FIFO with the multiplier held busy
        exp_q = '{16'h0001, 16'h0006, 16'h0014, 16'h002A, 16'h0048};
        force_busy = 1'b1;
        tick();
        push(8'h01, 8'h01);
        push(8'h02, 8'h03);
        push(8'h04, 8'h05);
        push(8'h06, 8'h07);
        check_eq("s3_full", bus.in_ready, 0);
        force_busy = 1'b0;
        push(8'h08, 8'h09);
        wait_out("s3_first_valid");
        check_eq("s3_first", bus.out_result, 16'h0001);
        for (int i = 0; i < 5; i++) tick();
        check_eq("s3_hold_valid", bus.out_valid, 1);
        check_eq("s3_hold_result", bus.out_result, 16'h0001);
        bus.out_ready = 1'b1;
        idx = 0;
        for (int i = 0; i < 300 && idx < 5; i++) begin
            if (bus.out_valid) begin
                check_eq($sformatf("s3_drain%0d", idx), bus.out_result, exp_q[idx]);
                idx++;
            end
            tick();
        end
        check_eq("s3_drain_count", idx, 5);
        bus.out_ready = 1'b0;

        // Stray done while idle must not create a result
        inject_req = inject_req + 1;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) seen_valid++;
        end
        check_eq("s4_stray_done", seen_valid, 0);

        // Reset during WAIT; the multiplier keeps running and later fires a stale done
        lat = 8;
        push(8'h03, 8'h04);
        wait_start("s5_start");
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("s5_rst_mul_a", bus.mul_a, 8'h00);
        check_eq("s5_rst_mul_start", bus.mul_start, 0);
        check_eq("s5_rst_out_result", bus.out_result, 16'h0000);
        check_eq("s5_rst_in_ready", bus.in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        seen_valid = 0;
        seen_start = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) seen_valid++;
            if (bus.mul_start) seen_start++;
        end
        check_eq("s5_no_stale_valid", seen_valid, 0);
        check_eq("s5_no_stale_start", seen_start, 0);
        lat = 3;
        push(8'h02, 8'h05);
        wait_out("s5_valid");
        check_eq("s5_result", bus.out_result, 16'h000A);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Multiplier never answers
        hang = 1'b1;
        push(8'h09, 8'h09);
        wait_start("s6_start");
        n = 0;
        while (!bus.err && n < 300) begin
            tick();
            n++;
        end
        check_eq("s6_timeout_cycles", n, TIMEOUT + 1);
        check_eq("s6_err", bus.err, 1);
        check_eq("s6_no_valid", bus.out_valid, 0);
        hang = 1'b0;
        push(8'h02, 8'h03);
        wait_out("s6_recover_valid");
        check_eq("s6_recover", bus.out_result, 16'h0006);
        check_eq("s6_err_sticky", bus.err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: operand-FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 63: maximum WAIT cycles allowed for mul_done, range 40..255.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1: operand-pair handshake.
REQ-006 SHALL have ports in_a input 8 / in_b input 8: two's-complement operands.
REQ-007 SHALL have ports out_valid output 1 / out_ready input 1: result handshake.
REQ-008 SHALL have port out_result  output  16  signed product.
REQ-009 SHALL have ports mul_start output 1 / mul_a output 8 / mul_b output 8: drive to the multiplier.
REQ-010 SHALL have ports mul_busy input 1 / mul_done input 1 / mul_result input 16: from the multiplier.
REQ-011 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-012 SHALL buffer {in_a,in_b} in a DEPTH-entry FIFO: push on in_valid&&in_ready; in_ready = !full (combinational from count).
REQ-013 SHALL wrap FIFO pointers modulo DEPTH and keep an occupancy count 0..DEPTH; push and pop in the same cycle leave count unchanged.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPTURE.
REQ-015 IDLE->ISSUE SHALL occur only when FIFO non-empty && !mul_busy && !mul_done && !out_valid; otherwise the FSM stays in IDLE.
REQ-016 On IDLE->ISSUE, mul_a/mul_b SHALL load the FIFO head and hold stable until the next IDLE->ISSUE.
REQ-017 In ISSUE, mul_start SHALL be 1 for exactly that one cycle, the FIFO head SHALL pop, and the FSM SHALL go to WAIT.
REQ-018 mul_start SHALL be 0 in every state other than ISSUE.
REQ-019 In WAIT: mul_done=1 -> CAPTURE. Otherwise the wait counter increments.
REQ-020 The wait counter SHALL clear in ISSUE.
REQ-021 In WAIT, if the wait counter reaches TIMEOUT with no mul_done: err<=1, the operation is dropped, and the FSM goes to IDLE.
REQ-022 Multiplier contract: mul_done is a 1-cycle pulse, and mul_result is valid from the cycle after mul_done until the next start.
REQ-023 In CAPTURE (cycle after mul_done), out_result<=mul_result and out_valid<=1; the FSM then goes to IDLE.
REQ-024 out_valid and out_result SHALL hold while out_valid && !out_ready.
REQ-025 out_valid SHALL clear on the edge where out_valid && out_ready.
REQ-026 No arithmetic SHALL be performed on the product; out_result is mul_result bit-exact.
REQ-027 mul_done outside WAIT SHALL be ignored and SHALL NOT create a result.
REQ-028 Results SHALL emerge in operand acceptance order; at most one operation is in flight.

Reset
REQ-029 While rst_n=0, regardless of clk, the block SHALL hold:
- FSM=IDLE
- FIFO empty, pointers 0
- wait counter 0
- out_valid=0, out_result=16'h0000
- mul_start=0, mul_a=mul_b=8'h00
- err=0
- in_ready=1
REQ-030 Reset mid-operation SHALL discard FIFO contents and the in-flight result.
REQ-031 After reset, issue SHALL wait per REQ-015 until the un-reset multiplier reports !mul_busy && !mul_done.
REQ-032 err SHALL clear only by reset.

Verification
REQ-033 Push in_a=8'hFD, in_b=8'h05 -> mul_start one cycle with mul_a=8'hFD, mul_b=8'h05; out_result=16'hFFF1, out_valid=1 two cycles after mul_done.
REQ-034 Push 8'h7F*8'h7F, then 8'h80*8'h80 back-to-back -> outputs in order 16'h3F01, then 16'h4000; second mul_start only after first output accepted.
REQ-035 out_ready=0, push DEPTH+1 pairs -> in_ready falls after DEPTH accepts; first result held stable; out_ready=1 drains all in order.
REQ-036 rst_n low during WAIT -> all outputs to reset values immediately; stale mul_done ignored; no out_valid until a new push completes.
REQ-037 Multiplier model never asserts mul_done -> err=1 after TIMEOUT WAIT cycles, FSM back to IDLE; next pair (8'h02*8'h03) still yields 16'h0006.
